// File: rtl/axis_arb_pkg.sv
// Shared definitions for the packet round-robin arbiter.
//   - FSM state encoding (IDLE=0, GRANTED=1)
//   - rr_pick(): round-robin selection returning a one-hot grant
package axis_arb_pkg;

    // Upper bound on requesters; rr_pick works on vectors of this width.
    localparam int MAX_PORTS = 8;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GRANTED = 1'b1;

    // First requester at or after (last_grant+1) mod num_ports, one-hot.
    // Returns all zeros when nothing requests. Bits at or above num_ports
    // are never set, so callers may OR-reduce the result as "any winner".
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input logic [2:0]           last_grant,
        input int                   num_ports
    );
        logic [MAX_PORTS-1:0] gnt;
        logic                 found;
        int                   idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            idx = (int'(last_grant) + k) % num_ports;
            if (k <= num_ports && !found && req[idx[2:0]]) begin
                gnt[idx[2:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI Stream register slice.
//   axis_aclk / axis_reset : clock, synchronous active-high reset
//   in_valid / in_ready / in_data    : upstream side
//   out_valid / out_ready / out_data : downstream side (registered)
// in_ready is high whenever the register is empty or draining this cycle,
// so a drain and a load in the same cycle keep out_valid asserted.
module axis_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             axis_aclk,
    input  logic             axis_reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_packet_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI Stream datapath
// between NUM_PORTS flattened input streams. A grant is held from the
// first beat until the tlast beat is accepted; packets never interleave.
//   axis_aclk, axis_reset          : clock, synchronous active-high reset
//   axis_in_*  (flattened, port i at [i*W +: W]) : requesters
//   axis_out_* : single registered output beat
//   grant_onehot : current owner, zero while arbitrating
// Optional feature macro: AXIS_ARB_SRC_PORT_EN -- when defined, the grant
// one-hot is written into axis_out_tuser[SRC_PORT_LSB +: NUM_PORTS].
module axis_packet_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int TDATA_WIDTH  = 256,
    parameter  int TUSER_WIDTH  = 128,
    parameter  int NUM_PORTS    = 4,
    parameter  int SRC_PORT_LSB = 16,
    localparam int TKEEP_WIDTH  = TDATA_WIDTH / 8
) (
    input  logic                             axis_aclk,
    input  logic                             axis_reset,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0] axis_in_tdata,
    input  logic [NUM_PORTS*TKEEP_WIDTH-1:0] axis_in_tkeep,
    input  logic [NUM_PORTS*TUSER_WIDTH-1:0] axis_in_tuser,
    input  logic [NUM_PORTS-1:0]             axis_in_tlast,
    input  logic [NUM_PORTS-1:0]             axis_in_tvalid,
    output logic [NUM_PORTS-1:0]             axis_in_tready,
    output logic [TDATA_WIDTH-1:0]           axis_out_tdata,
    output logic [TKEEP_WIDTH-1:0]           axis_out_tkeep,
    output logic [TUSER_WIDTH-1:0]           axis_out_tuser,
    output logic                             axis_out_tlast,
    output logic                             axis_out_tvalid,
    input  logic                             axis_out_tready,
    output logic [NUM_PORTS-1:0]             grant_onehot
);

    localparam int BEAT_W = TDATA_WIDTH + TKEEP_WIDTH + TUSER_WIDTH + 1;

    // Parameter sanity, checked at elaboration.
    if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS ||
        SRC_PORT_LSB + NUM_PORTS > TUSER_WIDTH) begin : g_bad_params
        $error("axis_packet_rr_arbiter: illegal NUM_PORTS/SRC_PORT_LSB");
    end

    // Per-port views of the flattened buses.
    logic [NUM_PORTS-1:0][TDATA_WIDTH-1:0] port_tdata;
    logic [NUM_PORTS-1:0][TKEEP_WIDTH-1:0] port_tkeep;
    logic [NUM_PORTS-1:0][TUSER_WIDTH-1:0] port_tuser;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign port_tdata[p] = axis_in_tdata[p*TDATA_WIDTH +: TDATA_WIDTH];
        assign port_tkeep[p] = axis_in_tkeep[p*TKEEP_WIDTH +: TKEEP_WIDTH];
        assign port_tuser[p] = axis_in_tuser[p*TUSER_WIDTH +: TUSER_WIDTH];
    end

    logic [0:0]             state;
    logic [2:0]             last_grant;
    logic [2:0]             grant_idx;
    logic [MAX_PORTS-1:0]   req_pad;
    logic [MAX_PORTS-1:0]   pick;
    logic                   sel_valid;
    logic                   sel_tlast;
    logic [TDATA_WIDTH-1:0] sel_tdata;
    logic [TKEEP_WIDTH-1:0] sel_tkeep;
    logic [TUSER_WIDTH-1:0] sel_tuser;
    logic [TUSER_WIDTH-1:0] out_tuser_next;
    logic                   out_free;
    logic                   beat_accept;
    logic [BEAT_W-1:0]      out_beat;

    always_comb begin
        req_pad                  = '0;
        req_pad[NUM_PORTS-1:0]   = axis_in_tvalid;
    end

    assign pick = rr_pick(req_pad, last_grant, NUM_PORTS);

    // One-hot AND-OR mux; grant_onehot is zero in IDLE so nothing is selected.
    always_comb begin
        sel_tdata = '0;
        sel_tkeep = '0;
        sel_tuser = '0;
        sel_tlast = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_onehot[i]) begin
                sel_tdata |= port_tdata[i];
                sel_tkeep |= port_tkeep[i];
                sel_tuser |= port_tuser[i];
                sel_tlast |= axis_in_tlast[i];
                grant_idx  = 3'(i);
            end
        end
    end

    assign sel_valid = |(axis_in_tvalid & grant_onehot);

`ifdef AXIS_ARB_SRC_PORT_EN
    always_comb begin
        out_tuser_next                               = sel_tuser;
        out_tuser_next[SRC_PORT_LSB +: NUM_PORTS]    = grant_onehot;
    end
`else
    assign out_tuser_next = sel_tuser;
`endif

    // Reset gates tready so no beat is handshaken in a cycle that is
    // being thrown away.
    assign axis_in_tready = (state == ST_GRANTED && !axis_reset && out_free)
                          ? grant_onehot : '0;
    assign beat_accept    = |(axis_in_tvalid & axis_in_tready);

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state        <= ST_IDLE;
            grant_onehot <= '0;
            last_grant   <= 3'(NUM_PORTS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|pick) begin
                        state        <= ST_GRANTED;
                        grant_onehot <= pick[NUM_PORTS-1:0];
                    end
                end
                default: begin
                    if (beat_accept && sel_tlast) begin
                        state        <= ST_IDLE;
                        grant_onehot <= '0;
                        last_grant   <= grant_idx;
                    end
                end
            endcase
        end
    end

    axis_reg_slice #(.WIDTH(BEAT_W)) u_out_slice (
        .axis_aclk  (axis_aclk),
        .axis_reset (axis_reset),
        .in_valid   (sel_valid),
        .in_ready   (out_free),
        .in_data    ({sel_tlast, out_tuser_next, sel_tkeep, sel_tdata}),
        .out_valid  (axis_out_tvalid),
        .out_ready  (axis_out_tready),
        .out_data   (out_beat)
    );

    assign {axis_out_tlast, axis_out_tuser, axis_out_tkeep, axis_out_tdata} = out_beat;

endmodule

// File: doc/axis_packet_rr_arbiter.md
# axis_packet_rr_arbiter

Packet-granular round-robin arbiter that shares one AXI Stream datapath (the front-trim/header-strip stage and everything downstream) between NUM_PORTS flattened input streams. A grant is held from the first beat of a packet until its tlast beat is accepted, so packets are never interleaved. The output is a single registered stage, so the shared datapath sees clean, registered tvalid/tdata.

## Interface
- TDATA_WIDTH, 256: data width per port, multiple of 8
- TUSER_WIDTH, 128: sideband width per port
- NUM_PORTS, 4: number of requesters, 2..8
- SRC_PORT_LSB, 16: tuser bit offset of the one-hot source-port field (used only with AXIS_ARB_SRC_PORT_EN)
- TKEEP_WIDTH: local, TDATA_WIDTH/8

Ports:
- axis_aclk  in  1  sole clock
- axis_reset  in  1  reset, synchronous, active-high
- axis_in_tdata  in  NUM_PORTS*TDATA_WIDTH  port i at slice [i*TDATA_WIDTH +: TDATA_WIDTH]
- axis_in_tkeep  in  NUM_PORTS*TKEEP_WIDTH  per-port keep, same slicing
- axis_in_tuser  in  NUM_PORTS*TUSER_WIDTH  per-port sideband, same slicing
- axis_in_tlast  in  NUM_PORTS  per-port last
- axis_in_tvalid  in  NUM_PORTS  per-port valid
- axis_in_tready  out  NUM_PORTS  per-port ready; at most one bit high per cycle
- axis_out_tdata/tkeep/tuser/tlast  out  TDATA_WIDTH/TKEEP_WIDTH/TUSER_WIDTH/1  registered beat
- axis_out_tvalid  out  1  registered valid
- axis_out_tready  in  1  downstream ready
- grant_onehot  out  NUM_PORTS  current owner; 0 in IDLE

## Operation
- States: IDLE, GRANTED.
- IDLE: requesters are the ports with tvalid high. Select the first requester at or after index (last_grant+1) mod NUM_PORTS. Register grant_onehot, go to GRANTED. No requesters: stay in IDLE. All axis_in_tready are 0 in IDLE.
- GRANTED: axis_in_tready[g] = out_free, where out_free = ~axis_out_tvalid | axis_out_tready. All other tready bits are 0. An accepted beat (tvalid & tready on port g) loads the output register.
- Accepted beat with tlast=1: update last_grant to g, clear grant_onehot, go to IDLE.
- Output register: loads on an accepted beat. tvalid is cleared when axis_out_tready & axis_out_tvalid and no new beat loads. tdata/tkeep/tuser/tlast pass unaltered (see Configuration).
- tkeep is not inspected. Packets with tkeep=0 beats pass through as-is.
- last_grant resets to NUM_PORTS-1, so port 0 wins the first arbitration.

## Timing
- Reset values: axis_out_tvalid=0, axis_out_tdata/tkeep/tuser/tlast=0, axis_in_tready=0, grant_onehot=0, state=IDLE.
- Latency: 1 cycle from an accepted input beat to axis_out_tvalid.
- Throughput: 1 beat/cycle within a packet under continuous axis_out_tready.
- Each packet costs one IDLE arbitration cycle. Back-to-back single-beat packets therefore sustain 1 beat per 2 cycles.
- Backpressure: while axis_out_tvalid=1 and axis_out_tready=0, output is held stable and input tready=0.
- Simultaneous drain and load in the same cycle is legal and keeps tvalid=1.
- Once asserted, an input tvalid is never required to stay high across IDLE. Arbitration samples only the current cycle.
- Reset asserted mid-packet: next cycle all outputs return to reset values. The partial packet is dropped and its sender must restart it.

## Configuration
- AXIS_ARB_SRC_PORT_EN defined: axis_out_tuser[SRC_PORT_LSB +: NUM_PORTS] is overwritten with the grant one-hot on every beat. Other tuser bits pass unaltered.
- Not defined: tuser passes entirely unaltered, and SRC_PORT_LSB is unused.

## Structure
- Shared package axis_arb_pkg holds the state encoding (IDLE=0, GRANTED=1) and a function rr_pick(req, last_grant) returning a one-hot grant.
- One sub-module: axis_reg_slice, the single-stage output register with the valid/ready rule above. It is reusable elsewhere in the pipeline.
- Arbiter FSM and per-port muxing stay in the top.

## Test plan
- Reset release, port 2 sends a 3-beat packet, out_tready=1 -> beats appear on cycles N+2..N+4 (one IDLE cycle, then 1-cycle latency); grant_onehot=0100 during the packet.
- Ports 0,1,3 all valid with 2-beat packets -> output order 0,1,3,0,...; no beat interleaving; tready one-hot every cycle.
- out_tready toggles 1,0,1,0 during a 4-beat packet -> no beat lost or duplicated; output stable while stalled; 8-cycle transfer.
- Port 1 holds tvalid with a 1-beat packet while port 0 streams a 5-beat packet -> port 1 is granted only after port 0's tlast is accepted.
- axis_reset asserted on beat 2 of a 4-beat packet -> next cycle tvalid=0, grant_onehot=0, tready=0; after release, port 0 wins the first arbitration.
- AXIS_ARB_SRC_PORT_EN defined, port 3 sends tuser=0 -> out tuser[19:16]=4'b1000, all other bits 0; without the macro, tuser=0 on output.
